// File: rtl/nexys4_disp_pkg.sv
// Shared constants for the Nexys4 display AXI slave:
// register offsets, response codes and the hex-to-segment table.
package nexys4_disp_pkg;

  // Register index taken from addr[3:2]
  localparam logic [1:0] REG_DIGITS  = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_DP      = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/nexys4_hex7seg.sv
// Combinational nibble + dp to active-low segment converter.
// Ports: nibble, dp in; seg {dp,g,f,e,d,c,b,a} out.
module nexys4_hex7seg
  import nexys4_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/nexys4_disp_axi_slave.sv
// AXI4-Lite slave with four 32-bit registers driving a
// scanned 8-digit seven-segment display (an/seg active-low).
module nexys4_disp_axi_slave
  import nexys4_disp_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int REFRESH_DIV        = 100000
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [7:0]                      an,
  output logic [7:0]                      seg
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          bus_en;
  logic                          wr_acc;
  logic                          rd_acc;
  logic [1:0]                    wr_idx;
  logic [1:0]                    rd_idx;

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic          cur_en;
  logic [7:0]    seg_next;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_idx = s00_axi_awaddr[3:2];
  assign rd_idx = s00_axi_araddr[3:2];

  // bus_en is held low through reset so the readies stay low
  // while reset is asserted even though they follow valid.
  assign wr_acc = bus_en & s00_axi_awvalid & s00_axi_wvalid
                & ~s00_axi_bvalid;
  assign rd_acc = bus_en & s00_axi_arvalid & ~s00_axi_rvalid;

  assign s00_axi_awready = wr_acc;
  assign s00_axi_wready  = wr_acc;
  assign s00_axi_arready = rd_acc;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      bus_en         <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      bus_en <= 1'b1;
      if (wr_acc) begin
        for (int b = 0; b < NB; b++)
          if (s00_axi_wstrb[b])
            regs[wr_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= RESP_OKAY;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // rdata samples the pre-write value on a same-cycle collision
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (rd_acc) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= regs[rd_idx];
      s00_axi_rresp  <= RESP_OKAY;
    end else if (s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  assign cur_nib = regs[REG_DIGITS][{idx, 2'b00} +: 4];
  assign cur_dp  = regs[REG_DP][{2'b00, idx}];
  assign cur_en  = regs[REG_ENABLE][{2'b00, idx}];

  nexys4_hex7seg u_hex (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (seg_next)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      pre <= '0;
      idx <= '0;
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        idx <= idx + 3'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      an  <= cur_en ? ~(8'h01 << idx) : 8'hFF;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_nexys4_disp_axi_slave.sv
// Self-checking bench: random AXI traffic against a register
// model plus display scan checks with REFRESH_DIV=4.
module tb_nexys4_disp_axi_slave;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;

  int passed = 0;
  int total  = 0;

  logic [31:0] m [4];
  logic [6:0]  hexp [16];
  int unsigned edges;

  always #5 clk = ~clk;

  nexys4_disp_axi_slave #(.REFRESH_DIV(DIV)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .an              (an),
    .seg             (seg)
  );

  // Rising edges seen since the last reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(awready && wready) && n < 20);
    chk("wr_accept", {30'd0, awready, wready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    m[a[3:2]] = merge(m[a[3:2]], d, s);
    @(negedge clk);
    chk("bvalid", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!arready && n < 20);
    chk("rd_accept", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk("rresp", {30'd0, rresp}, 32'd0);
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a);
    logic [31:0] d;
    axi_read(a, d);
    chk(tag, d, m[a[3:2]]);
  endtask

  task automatic scan_check(input int cycles);
    int k;
    logic [7:0] ea;
    logic [7:0] es;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      // outputs reflect the digit selected before the last edge
      k = ((int'(edges) - 1) / DIV) % 8;
      ea = m[1][k] ? ~(8'h01 << k) : 8'hFF;
      es = {~m[2][k], hexp[m[0][4*k +: 4]]};
      chk("an", {24'd0, an}, {24'd0, ea});
      chk("seg", {24'd0, seg}, {24'd0, es});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int acc;
    hexp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 4; i++) m[i] = '0;

    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #23;
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // basic map
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d);
      chk("map_rd", d, 32'(i + 1));
    end

    // byte strobes
    axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
    axi_write(4'hC, 32'h00000000, 4'b0101);
    axi_read(4'hC, d);
    chk("strobe", d, 32'hFF00FF00);

    // address before data, stalled response
    awaddr = 4'hC; wdata = 32'h5A5A_1234; wstrb = 4'hF;
    awvalid = 1'b1; bready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("aw_early", {30'd0, awready, wready}, 32'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_coinc", {30'd0, awready, wready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    m[3] = 32'h5A5A_1234;
    repeat (5) begin
      @(negedge clk);
      chk("b_hold", {31'd0, bvalid}, 32'd1);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    chk("b_clear", {31'd0, bvalid}, 32'd0);
    bready = 1'b0;
    read_chk("stall_rd", 4'hC);

    // throughput: 2 writes in 4 cycles with bready held
    awaddr = 4'hC; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (awready && wready) acc++;
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    bready = 1'b0;
    m[3] = 32'h0BAD_F00D;
    chk("wr_thruput", 32'(acc), 32'd2);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        axi_write(4'($urandom_range(3, 0) * 4), $urandom,
                  4'($urandom_range(15, 0)));
      else
        read_chk("rand_rd", 4'($urandom_range(3, 0) * 4));
    end

    // display scan, fixed pattern
    axi_write(4'h0, 32'h76543210, 4'hF);
    axi_write(4'h4, 32'h05, 4'hF);
    axi_write(4'h8, 32'h01, 4'hF);
    scan_check(40);

    // display scan, random patterns
    repeat (3) begin
      axi_write(4'h0, $urandom, 4'hF);
      axi_write(4'h4, $urandom, 4'hF);
      axi_write(4'h8, $urandom, 4'hF);
      scan_check(36);
    end

    // same-cycle read and write of SCRATCH
    axi_write(4'hC, 32'hA, 4'hF);
    awaddr = 4'hC; wdata = 32'hB; wstrb = 4'hF;
    araddr = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("coll_acc", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("coll_old", rdata, 32'hA);
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    m[3] = 32'hB;
    read_chk("coll_new", 4'hC);

    // reset with a pending write response
    awaddr = 4'h4; wdata = 32'hFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("pend_b", {31'd0, bvalid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_b", {31'd0, bvalid}, 32'd0);
    chk("abort_an", {24'd0, an}, 32'hFF);
    chk("abort_seg", {24'd0, seg}, 32'hFF);
    for (int i = 0; i < 4; i++) m[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_b", {31'd0, bvalid}, 32'd0);
    for (int i = 0; i < 4; i++) read_chk("post_rst", 4'(i * 4));
    scan_check(16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nexys4_disp_axi_slave.md
NEXYS4_DISP_AXI_SLAVE -- requirements
Module: nexys4_disp_axi_slave

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width covering four 32-bit registers.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per displayed digit, minimum 2.
REQ-004 s00_axi_aclk  in  1  single clock; all logic on the rising edge.
REQ-005 s00_axi_aresetn  in  1  reset, asynchronous and active-low.
REQ-006 s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  4/3/1/1  write address channel; awprot is ignored.
REQ-007 s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-008 s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-009 s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  4/3/1/1  read address channel; arprot is ignored.
REQ-010 s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-011 an  out  8  digit anodes, active-low, one-hot-low while scanning.
REQ-012 seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-013 Register map, selected by addr[3:2]: 0x0 DIGITS (eight hex nibbles, digit k = bits [4k+3:4k]); 0x4 ENABLE (bits [7:0] enable digits); 0x8 DP (bits [7:0] decimal points); 0xC SCRATCH.
REQ-014 All 32 bits of every register SHALL be stored and read back unchanged, with no reserved bits and no side effects.
REQ-015 Write SHALL be accepted only when awvalid and wvalid are both high and bvalid is low; awready and wready SHALL then pulse high together for exactly one cycle.
REQ-016 The register update SHALL occur on the acceptance edge, per byte lane where wstrb[i]=1.
REQ-017 bvalid SHALL rise on the cycle after acceptance and SHALL hold with bresp=OKAY (2'b00) until bready is sampled high.
REQ-018 Read SHALL be accepted when arvalid is high and rvalid is low; arready SHALL pulse for one cycle.
REQ-019 rdata SHALL be latched at read acceptance, and rvalid SHALL rise the next cycle and hold with rdata stable and rresp=OKAY until rready is sampled high.
REQ-020 Read and write channels SHALL be independent; if both are accepted in the same cycle to the same register, rdata SHALL return the pre-write value.
REQ-021 Back-to-back throughput SHALL be one transaction per two cycles per channel when bready or rready is held high.
REQ-022 Scanner: a prescale counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index 0..7 SHALL advance, with 7 wrapping to 0.
REQ-023 For digit index k: an[k]=0 only if ENABLE[k]=1, otherwise an=8'hFF.
REQ-024 For digit index k: seg[6:0] SHALL be the active-low hex pattern of DIGITS nibble k, and seg[7]=~DP[k].
REQ-025 an and seg SHALL be registered outputs, taking effect one cycle after the index or register change.

Reset
REQ-026 While s00_axi_aresetn=0, all four registers, the prescaler and the digit index SHALL be 0, and awready, wready, bvalid, arready and rvalid SHALL be 0.
REQ-027 While s00_axi_aresetn=0, rdata=0, bresp=0, rresp=0, an=8'hFF and seg=8'hFF.
REQ-028 Reset asserted mid-transaction SHALL abort it with no response issued; the first transaction after release SHALL behave as from idle.

Structure
REQ-029 A shared package nexys4_disp_pkg SHALL hold the register offsets, the OKAY/SLVERR encodings and the 16-entry hex-to-segment table.
REQ-030 One sub-module, nexys4_hex7seg, SHALL convert a 4-bit nibble plus dp into the 8-bit active-low seg value, and SHALL be purely combinational.

Verification
REQ-031 Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back -> 0x1, 0x2, 0x3, 0x4, bresp=rresp=OKAY.
REQ-032 Write 0xFFFFFFFF then 0x00000000 with wstrb=4'b0101 to SCRATCH -> read returns 0xFF00FF00.
REQ-033 Present awvalid 3 cycles before wvalid -> no awready until wvalid is high, then awready and wready are coincident; hold bready=0 for 5 cycles -> bvalid stays high.
REQ-034 REFRESH_DIV=4, DIGITS=0x76543210, ENABLE=0x05, DP=0x01 -> an sequence FE,FF,FB,FF... changing every 4 cycles; seg=0x40 on digit 0 and seg=0xA4 on digit 2.
REQ-035 Same-cycle read and write of SCRATCH (old value 0xA, new value 0xB) -> rdata=0xA, and a following read returns 0xB.
REQ-036 Assert reset while bvalid is pending -> bvalid=0, an=FF, and all registers read back 0 after release.
